tft_spi_tx: RTL and testbench

- Byte-level SPI transmitter for the TFT panel; directly downstream of the init/draw sequencers.
- Accepts one command/data byte per tft_transmit strobe, with its D/C flag.
- Shifts the byte out MSB-first in SPI mode 0 with chip-select framing.
- Drives the panel D/C pin and reports tft_busy back to the sequencer.

---
 rtl/tft_spi_tx_if.sv | 11 +
 rtl/tft_spi_tx.sv | 180 ++++++++++++++++++
 tb/tb_tft_spi_tx.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tft_spi_tx_if.sv
// Sequencer-side byte handshake of the TFT SPI transmitter.
// The master drives byte strobes; the slave (transmitter) reports busy.
interface tft_spi_tx_if;
    logic       tft_transmit;
    logic       tft_dc;
    logic [7:0] tft_data;
    logic       tft_busy;

    modport master (output tft_transmit, output tft_dc, output tft_data, input tft_busy);
    modport slave  (input tft_transmit, input tft_dc, input tft_data, output tft_busy);
endinterface

// File: rtl/tft_spi_tx.sv
// Byte-level SPI mode-0 transmitter for the TFT panel (MSB first, CS framing, D/C pin).
// Define TFT_SPI_BUF_EN to add a one-byte pending buffer in front of the shifter.
module tft_spi_tx #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    tft_spi_tx_if.slave host,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_dc
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [1:0] state_r;
    logic [7:0] div_r;
    logic [2:0] bit_r;
    logic [7:0] shift_r;
    logic       busy_r;
    logic       sck_r;
    logic       mosi_r;
    logic       cs_n_r;
    logic       dc_r;
    logic       div_done_s;
    logic       gap_end_s;
    logic       load_s;
    logic [8:0] load_word_s;

    assign div_done_s = (div_r == DIV_LAST);
    assign gap_end_s  = (state_r == ST_GAP) && div_done_s;

`ifdef TFT_SPI_BUF_EN
    logic [8:0] buf_r;
    logic       buf_valid_r;
    logic       load_buf_s;
    logic       store_s;

    // Decide whether the shifter loads (from buffer first) or the strobe is parked
    always_comb begin
        load_s      = 1'b0;
        load_buf_s  = 1'b0;
        store_s     = 1'b0;
        load_word_s = {host.tft_dc, host.tft_data};
        if (buf_valid_r && ((state_r == ST_IDLE) || gap_end_s)) begin
            load_s      = 1'b1;
            load_buf_s  = 1'b1;
            load_word_s = buf_r;
        end else if (host.tft_transmit && !buf_valid_r) begin
            if (state_r == ST_IDLE) begin
                load_s = 1'b1;
            end else begin
                store_s = 1'b1;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Pending buffer; busy mirrors the buffer occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_r       <= 9'd0;
            buf_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (load_buf_s) begin
            buf_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (store_s) begin
            buf_r       <= {host.tft_dc, host.tft_data};
            buf_valid_r <= 1'b1;
            busy_r      <= 1'b1;
        end else begin
            busy_r      <= buf_valid_r;
        end
    end
`else
    // Accept a byte only when the shifter is idle
    always_comb begin
        load_word_s = {host.tft_dc, host.tft_data};
        if ((state_r == ST_IDLE) && host.tft_transmit) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Busy covers the whole frame from acceptance to the end of the CS gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else if (load_s) begin
            busy_r <= 1'b1;
        end else if (gap_end_s) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= busy_r;
        end
    end
`endif

    // Frame sequencer: CS setup, 8 SCK periods, CS-high gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            div_r   <= 8'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            sck_r   <= 1'b0;
            mosi_r  <= 1'b0;
            cs_n_r  <= 1'b1;
            dc_r    <= 1'b0;
        end else if (load_s) begin
            state_r <= ST_SETUP;
            div_r   <= 8'd0;
            bit_r   <= 3'd0;
            shift_r <= load_word_s[7:0];
            mosi_r  <= load_word_s[7];
            dc_r    <= load_word_s[8];
            cs_n_r  <= 1'b0;
            sck_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    div_r <= 8'd0;
                end
                ST_SETUP: begin
                    if (div_done_s) begin
                        state_r <= ST_SHIFT;
                        sck_r   <= 1'b1;
                        div_r   <= 8'd0;
                    end else begin
                        div_r   <= div_r + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (!div_done_s) begin
                        div_r <= div_r + 8'd1;
                    end else begin
                        div_r <= 8'd0;
                        // MOSI only moves together with the SCK falling edge
                        if (sck_r) begin
                            sck_r   <= 1'b0;
                            shift_r <= {shift_r[6:0], 1'b0};
                            mosi_r  <= shift_r[6];
                        end else if (bit_r == 3'd7) begin
                            state_r <= ST_GAP;
                            cs_n_r  <= 1'b1;
                            bit_r   <= bit_r + 3'd1;
                        end else begin
                            bit_r   <= bit_r + 3'd1;
                            sck_r   <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (div_done_s) begin
                        state_r <= ST_IDLE;
                        div_r   <= 8'd0;
                    end else begin
                        div_r   <= div_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign host.tft_busy = busy_r;
    assign spi_sck       = sck_r;
    assign spi_mosi      = mosi_r;
    assign spi_cs_n      = cs_n_r;
    assign spi_dc        = dc_r;
endmodule

// File: tb/tb_tft_spi_tx.sv
// Self-checking bench for tft_spi_tx: vector table, corner sequences and a random run
// checked by a frame-level reference model (expected byte queue plus busy timing).
`timescale 1ns/1ps
module tb_tft_spi_tx;
    localparam int D_A = 2;
    localparam int D_B = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tft_spi_tx_if ifa ();
    tft_spi_tx_if ifb ();
    logic a_sck, a_mosi, a_cs_n, a_dc;
    logic b_sck, b_mosi, b_cs_n, b_dc;

    tft_spi_tx #(.CLK_DIV(D_A)) dut_a (.clk(clk), .rst(rst), .host(ifa),
        .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_cs_n(a_cs_n), .spi_dc(a_dc));
    tft_spi_tx #(.CLK_DIV(D_B)) dut_b (.clk(clk), .rst(rst), .host(ifb),
        .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_cs_n(b_cs_n), .spi_dc(b_dc));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a byte is accepted when the transmitter is free, and
    // the transmitter is then occupied for 18*CLK_DIV clocks.
    int         mdl_cnt;
    logic       mdl_pend;
    logic [8:0] exp_q[$];

    always @(posedge clk or posedge rst) begin : model
        int  c;
        logic p;
        if (rst) begin
            mdl_cnt  <= 0;
            mdl_pend <= 1'b0;
            exp_q.delete();
        end else begin
            c = mdl_cnt;
            p = mdl_pend;
`ifdef TFT_SPI_BUF_EN
            if (c == 0) begin
                if (p) begin
                    c = 18 * D_A;
                    p = 1'b0;
                end else if (ifa.tft_transmit) begin
                    c = 18 * D_A;
                    exp_q.push_back({ifa.tft_dc, ifa.tft_data});
                end
            end else begin
                if (c == 1 && p) begin
                    c = 18 * D_A;
                    p = 1'b0;
                end else begin
                    c = c - 1;
                    if (ifa.tft_transmit && !p) begin
                        p = 1'b1;
                        exp_q.push_back({ifa.tft_dc, ifa.tft_data});
                    end
                end
            end
`else
            if (c > 0) begin
                c = c - 1;
            end else if (ifa.tft_transmit) begin
                c = 18 * D_A;
                exp_q.push_back({ifa.tft_dc, ifa.tft_data});
            end
`endif
            mdl_cnt  <= c;
            mdl_pend <= p;
        end
    end

    logic exp_busy;
`ifdef TFT_SPI_BUF_EN
    assign exp_busy = mdl_pend;
`else
    assign exp_busy = (mdl_cnt > 0);
`endif

    // Wire monitor for DUT A: decodes frames and checks them against the model
    logic       m_psck = 1'b0, m_pmosi = 1'b0, m_pcs = 1'b1;
    logic       frame_dc = 1'b0;
    logic [7:0] frame_bits = 8'h00;
    int         frame_pulses = 0, hi_run = 0, lo_run = 0, cs_hi_run = 0, frames_done = 0;

    always @(negedge clk) begin : monitor
        logic [8:0] w;
        if (rst) begin
            frame_pulses = 0;
            hi_run       = 0;
            lo_run       = 0;
            cs_hi_run    = 0;
        end else begin
            chk("busy_vs_model", ifa.tft_busy, exp_busy);
            if (!a_cs_n && m_pcs) begin
                chk("cs_high_gap_min", (cs_hi_run >= D_A), 1);
                frame_pulses = 0;
                frame_dc     = a_dc;
            end
            if (!a_cs_n) chk("dc_stable_in_frame", a_dc, frame_dc);
            if (a_sck && !m_psck) begin
                chk("sck_inside_cs", a_cs_n, 0);
                chk("sck_low_width", lo_run, D_A);
                frame_bits = {frame_bits[6:0], a_mosi};
                frame_pulses++;
            end
            if (a_sck && m_psck) chk("mosi_hold_while_sck_high", a_mosi, m_pmosi);
            if (!a_sck && m_psck) chk("sck_high_width", hi_run, D_A);
            if (a_cs_n && !m_pcs) begin
                chk("frame_pulses", frame_pulses, 8);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("frame_byte", frame_bits, w[7:0]);
                    chk("frame_dc", frame_dc, w[8]);
                end
                frames_done++;
            end
            hi_run    = a_sck ? hi_run + 1 : 0;
            lo_run    = (!a_sck && !a_cs_n) ? lo_run + 1 : 0;
            cs_hi_run = a_cs_n ? cs_hi_run + 1 : 0;
        end
        m_psck  = a_sck;
        m_pmosi = a_mosi;
        m_pcs   = a_cs_n;
    end

    // Strobe one byte into DUT A and measure busy length and the MOSI stream;
    // optionally re-strobe 0xFF at loop index inj while the byte is in flight.
    task automatic send_measure(input logic dc, input logic [7:0] data, input int inj,
                                output int busy_len, output logic [7:0] bits, output int pulses);
        logic prev;
        ifa.tft_dc       = dc;
        ifa.tft_data     = data;
        ifa.tft_transmit = 1'b1;
        @(negedge clk);
        busy_len = 0;
        pulses   = 0;
        bits     = 8'h00;
        prev     = a_sck;
        for (int i = 0; i < 200; i++) begin
            ifa.tft_transmit = (i == inj);
            if (i == inj) ifa.tft_data = 8'hFF;
            if (a_sck && !prev) begin
                bits = {bits[6:0], a_mosi};
                pulses++;
            end
            prev = a_sck;
            if (!ifa.tft_busy) break;
            busy_len++;
            @(negedge clk);
        end
        ifa.tft_transmit = 1'b0;
    endtask

`ifndef TFT_SPI_BUF_EN
    typedef struct {
        logic       dc;
        logic [7:0] data;
        int         inj;
        logic [7:0] exp_bits;
        int         exp_busy;
        int         exp_pulses;
    } vec_t;
    vec_t vecs[5];
`endif

    int         blen, bpulses, rises, last_rise, frames_before;
    logic [7:0] bbits;
    logic       prev_s;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ifa.tft_transmit = 1'b0; ifa.tft_dc = 1'b0; ifa.tft_data = 8'h00;
        ifb.tft_transmit = 1'b0; ifb.tft_dc = 1'b0; ifb.tft_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_busy", ifa.tft_busy, 0);
        chk("reset_sck", a_sck, 0);
        chk("reset_mosi", a_mosi, 0);
        chk("reset_cs_n", a_cs_n, 1);
        chk("reset_dc", a_dc, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifndef TFT_SPI_BUF_EN
        vecs[0] = '{1'b1, 8'hA5, -1, 8'b10100101, 36, 8};
        vecs[1] = '{1'b0, 8'h00, -1, 8'b00000000, 36, 8};
        vecs[2] = '{1'b1, 8'hFF, -1, 8'b11111111, 36, 8};
        vecs[3] = '{1'b0, 8'h3C, -1, 8'b00111100, 36, 8};
        vecs[4] = '{1'b1, 8'h5A, 10, 8'b01011010, 36, 8};
        for (int v = 0; v < 5; v++) begin
            send_measure(vecs[v].dc, vecs[v].data, vecs[v].inj, blen, bbits, bpulses);
            chk($sformatf("vec%0d_busy_len", v), blen, vecs[v].exp_busy);
            chk($sformatf("vec%0d_mosi_bits", v), bbits, vecs[v].exp_bits);
            chk($sformatf("vec%0d_sck_pulses", v), bpulses, vecs[v].exp_pulses);
            repeat (3) @(negedge clk);
        end

        // Back-to-back: second strobe on the first cycle busy is low
        send_measure(1'b0, 8'h2A, -1, blen, bbits, bpulses);
        chk("b2b_first_bits", bbits, 8'h2A);
        send_measure(1'b1, 8'h01, -1, blen, bbits, bpulses);
        chk("b2b_second_bits", bbits, 8'h01);
        chk("b2b_second_busy", blen, 36);
        repeat (3) @(negedge clk);

        // Asynchronous reset after the third SCK rise of 0xC0
        ifa.tft_dc = 1'b0; ifa.tft_data = 8'hC0; ifa.tft_transmit = 1'b1;
        @(negedge clk);
        ifa.tft_transmit = 1'b0;
        rises  = 0;
        prev_s = a_sck;
        for (int i = 0; i < 100 && rises < 3; i++) begin
            @(negedge clk);
            if (a_sck && !prev_s) rises++;
            prev_s = a_sck;
        end
        chk("rst_third_rise_seen", rises, 3);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_cs_n", a_cs_n, 1);
        chk("rst_async_sck", a_sck, 0);
        chk("rst_async_busy", ifa.tft_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_measure(1'b1, 8'h96, -1, blen, bbits, bpulses);
        chk("post_rst_bits", bbits, 8'h96);
        chk("post_rst_busy", blen, 36);
        chk("post_rst_pulses", bpulses, 8);

        // CLK_DIV=1 instance, byte 0x80
        ifb.tft_dc = 1'b1; ifb.tft_data = 8'h80; ifb.tft_transmit = 1'b1;
        @(negedge clk);
        ifb.tft_transmit = 1'b0;
        blen = 0; bpulses = 0; bbits = 8'h00; last_rise = -1; prev_s = b_sck;
        for (int i = 0; i < 100; i++) begin
            if (b_sck && !prev_s) begin
                bbits = {bbits[6:0], b_mosi};
                if (bpulses > 0) chk("div1_sck_period", i - last_rise, 2);
                last_rise = i;
                bpulses++;
            end
            prev_s = b_sck;
            if (!ifb.tft_busy) break;
            blen++;
            @(negedge clk);
        end
        chk("div1_busy_len", blen, 18);
        chk("div1_bits", bbits, 8'h80);
        chk("div1_pulses", bpulses, 8);
`else
        // Pending buffer: 0x11 then 0x29 two cycles later, third strobe ignored
        frames_before = frames_done;
        ifa.tft_dc = 1'b0; ifa.tft_data = 8'h11; ifa.tft_transmit = 1'b1;
        @(negedge clk);
        ifa.tft_transmit = 1'b0;
        @(negedge clk);
        chk("buf_busy_before_second", ifa.tft_busy, 0);
        ifa.tft_dc = 1'b1; ifa.tft_data = 8'h29; ifa.tft_transmit = 1'b1;
        @(negedge clk);
        ifa.tft_transmit = 1'b0;
        chk("buf_busy_rise", ifa.tft_busy, 1);
        blen = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 2) begin
                ifa.tft_dc = 1'b0; ifa.tft_data = 8'h77; ifa.tft_transmit = 1'b1;
            end else begin
                ifa.tft_transmit = 1'b0;
            end
            if (!ifa.tft_busy) break;
            blen++;
            @(negedge clk);
        end
        ifa.tft_transmit = 1'b0;
        chk("buf_busy_len", blen, 34);
        repeat (120) @(negedge clk);
        chk("buf_frames", frames_done - frames_before, 2);
        chk("buf_queue_drained", exp_q.size(), 0);
`endif

        // Random strobes, some landing while busy; the model decides acceptance
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 45)) @(negedge clk);
            ifa.tft_dc       = 1'($urandom_range(0, 1));
            ifa.tft_data     = 8'($urandom);
            ifa.tft_transmit = 1'b1;
            @(negedge clk);
            ifa.tft_transmit = 1'b0;
        end
        repeat (120) @(negedge clk);
        chk("random_queue_drained", exp_q.size(), 0);
        chk("random_idle_cs_n", a_cs_n, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
